// File: rtl/cond_fork5_sched.sv
// cond_fork5_sched: round-robin route arbiter, route FIFO and fork sequencer.
// Requester masks are queued, then presented one at a time to the 5-way
// conditional fork. For each route the block drives a launch pulse, waits for
// fire_i, then waits for every selected destination to return a free pulse.
module cond_fork5_sched #(
    parameter int NREQ  = 3,
    parameter int DEPTH = 4,
    parameter int TMO   = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [5*NREQ-1:0]        req_mask,
    output logic [NREQ-1:0]          req_ready,
    output logic [4:0]               valid_o,
    output logic                     drive_o,
    input  logic                     fire_i,
    input  logic [4:0]               free_i,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     busy,
    output logic                     zero_drop,
    output logic                     tmo_flag
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_FIRE = 2'd2;
    localparam logic [1:0] S_WAIT_FREE = 2'd3;

    logic [1:0]    state, state_nx;
    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    head;
    logic          q_empty, q_full;
    logic          push, pop, can_push;
    logic [4:0]    push_data;

    logic [PW-1:0] ptr, win_idx;
    logic          found;
    int            arb_idx;

    logic [4:0]    pend, pend_nx, valid_nx;
    logic [15:0]   wd_cnt;
    logic          wd_hit, wd_clr, tmo_set, zdrop;

    assign head     = mem[rd_ptr];
    assign q_empty  = (q_count == '0);
    assign q_full   = (q_count == CW'(DEPTH));
    assign can_push = !q_full || pop;
    assign wd_hit   = (wd_cnt == 16'(TMO - 1));

    // Round-robin search from ptr; one grant per cycle, only when a slot is free.
    always_comb begin
        found     = 1'b0;
        win_idx   = '0;
        arb_idx   = 0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            arb_idx = (int'(ptr) + k) % NREQ;
            if (!found && req_valid[arb_idx]) begin
                found   = 1'b1;
                win_idx = PW'(arb_idx);
            end
        end
        if (found && can_push)
            req_ready[win_idx] = 1'b1;
    end

    assign push      = |req_ready;
    assign push_data = req_mask[int'(win_idx)*5 +: 5];

    // Route sequencing; pop leaves the head on route completion, timeout or zero mask.
    always_comb begin
        state_nx = state;
        valid_nx = valid_o;
        pend_nx  = pend;
        pop      = 1'b0;
        zdrop    = 1'b0;
        tmo_set  = 1'b0;
        wd_clr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!q_empty) begin
                    if (head != 5'd0) begin
                        valid_nx = head;
                        state_nx = S_ISSUE;
                    end else begin
                        pop   = 1'b1;
                        zdrop = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                wd_clr   = 1'b1;
                state_nx = S_WAIT_FIRE;
            end
            S_WAIT_FIRE: begin
                if (fire_i) begin
                    // Frees coinciding with fire are dropped; pend starts full.
                    pend_nx  = valid_o;
                    wd_clr   = 1'b1;
                    state_nx = S_WAIT_FREE;
                end else if (wd_hit) begin
                    tmo_set  = 1'b1;
                    pop      = 1'b1;
                    valid_nx = 5'd0;
                    state_nx = S_IDLE;
                end
            end
            S_WAIT_FREE: begin
                pend_nx = pend & ~free_i;
                if (pend_nx == 5'd0) begin
                    pop      = 1'b1;
                    valid_nx = 5'd0;
                    state_nx = S_IDLE;
                end else if (wd_hit) begin
                    tmo_set  = 1'b1;
                    pop      = 1'b1;
                    valid_nx = 5'd0;
                    state_nx = S_IDLE;
                end
            end
            default: begin
                valid_nx = 5'd0;
                state_nx = S_IDLE;
            end
        endcase
    end

    // FSM, fork-facing registers, watchdog and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            valid_o  <= 5'd0;
            pend     <= 5'd0;
            wd_cnt   <= 16'd0;
            tmo_flag <= 1'b0;
        end else begin
            state   <= state_nx;
            valid_o <= valid_nx;
            pend    <= pend_nx;
            if (wd_clr)
                wd_cnt <= 16'd0;
            else if (state == S_WAIT_FIRE || state == S_WAIT_FREE)
                wd_cnt <= wd_cnt + 16'd1;
            if (tmo_set)
                tmo_flag <= 1'b1;
        end
    end

    // Queue pointers, occupancy and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
            ptr     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                ptr    <= PW'((int'(win_idx) + 1) % NREQ);
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                q_count <= q_count + 1'b1;
            else if (pop && !push)
                q_count <= q_count - 1'b1;
        end
    end

    // Queue storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    assign drive_o   = (state == S_ISSUE);
    assign busy      = (state != S_IDLE);
    assign zero_drop = zdrop;

endmodule
